// File: rtl/botupdt_irq_ctrl_if.sv
// Event/interrupt bundle for botupdt_irq_ctrl.
//   master : event source / CPU side (drives i_evt, i_mask, i_ack, i_cnt_clr)
//   slave  : the controller (drives o_pending, o_irq, o_miss_cnt)
// Signals:
//   i_evt      NUM_CH        async event levels
//   i_mask     NUM_CH        1 = channel may raise o_irq
//   i_ack      NUM_CH        1-cycle ack pulses
//   i_cnt_clr  1             clear all missed-event counters
//   o_pending  NUM_CH        sticky pending bits
//   o_irq      1             masked interrupt
//   o_miss_cnt NUM_CH*CNT_W  per-channel missed counts, ch n at [n*CNT_W +: CNT_W]
interface botupdt_irq_ctrl_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8
);
  logic [NUM_CH-1:0]       i_evt;
  logic [NUM_CH-1:0]       i_mask;
  logic [NUM_CH-1:0]       i_ack;
  logic                    i_cnt_clr;
  logic [NUM_CH-1:0]       o_pending;
  logic                    o_irq;
  logic [NUM_CH*CNT_W-1:0] o_miss_cnt;

  modport master (
    output i_evt, i_mask, i_ack, i_cnt_clr,
    input  o_pending, o_irq, o_miss_cnt
  );

  modport slave (
    input  i_evt, i_mask, i_ack, i_cnt_clr,
    output o_pending, o_irq, o_miss_cnt
  );
endinterface

// File: rtl/botupdt_irq_ctrl.sv
// Multi-channel event synchroniser, sticky-pending latch and ack controller.
// Each channel synchronises a foreign-domain event level, detects its rising
// edge and latches a pending bit until the CPU acks it. One masked interrupt.
// Ports:
//   clk  core clock
//   rst  synchronous active-high reset
//   bus  botupdt_irq_ctrl_if.slave (i_evt, i_mask, i_ack, i_cnt_clr in;
//        o_pending, o_irq, o_miss_cnt out)
// Configuration macro: BOTUPDT_MISS_CNT_EN builds the saturating missed-event
// counters; without it o_miss_cnt is tied to 0 and i_cnt_clr is ignored.
module botupdt_irq_ctrl #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  botupdt_irq_ctrl_if.slave  bus
);

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
  logic [NUM_CH-1:0] sync_out;
  logic [NUM_CH-1:0] hist_q;
  logic [NUM_CH-1:0] edge_q;
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] pend_d;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // New edge beats a coincident ack so the event is never lost.
  always_comb begin
    pend_d = edge_q | (pend_q & ~bus.i_ack);
  end

  // Synchroniser chain, edge history and a registered edge strobe; h resets
  // to 0 so a level already high at reset release counts as one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= '0;
      edge_q <= '0;
      pend_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.i_evt};
      hist_q <= sync_out;
      edge_q <= sync_out & ~hist_q;
      pend_q <= pend_d;
    end
  end

  assign bus.o_pending = pend_q;
  assign bus.o_irq     = |(pend_q & bus.i_mask);

`ifdef BOTUPDT_MISS_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_d;

  // Clear first, then a coincident miss still counts as one; saturate at max.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      if (bus.i_cnt_clr) begin
        cnt_d[ch] = '0;
      end
      if (edge_q[ch] && pend_q[ch] && !bus.i_ack[ch] && (cnt_d[ch] != CNT_MAX)) begin
        cnt_d[ch] = cnt_d[ch] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.o_miss_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = bus.i_cnt_clr;
  assign bus.o_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_botupdt_irq_ctrl.sv
// Self-checking bench for botupdt_irq_ctrl: a cycle model pushes expected
// pending/counter state per clock into a scoreboard queue, popped and
// compared after each edge, plus directed checks of the key scenarios.
module tb_botupdt_irq_ctrl;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned HD     = SYNC + 2;

  typedef struct packed {
    logic [NUM_CH-1:0]       pend;
    logic [NUM_CH*CNT_W-1:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  botupdt_irq_ctrl_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) ifc ();

  botupdt_irq_ctrl #(.NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  exp_t sb_q[$];
  logic [NUM_CH-1:0] m_hist [HD];
  logic [NUM_CH-1:0] m_pend;
  logic [CNT_W-1:0]  m_cnt [NUM_CH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pending sees evt sampled SYNC+1 edges earlier.
  task automatic model_step();
    logic [NUM_CH-1:0] e;
    exp_t x;
    if (rst) begin
      for (int i = 0; i < HD; i++) m_hist[i] = '0;
      for (int c = 0; c < NUM_CH; c++) m_cnt[c] = '0;
      m_pend = '0;
    end else begin
      e = m_hist[SYNC] & ~m_hist[SYNC+1];
`ifdef BOTUPDT_MISS_CNT_EN
      for (int c = 0; c < NUM_CH; c++) begin
        if (ifc.i_cnt_clr) m_cnt[c] = '0;
        if (e[c] && m_pend[c] && !ifc.i_ack[c] && m_cnt[c] != 3'd7)
          m_cnt[c] = m_cnt[c] + 3'd1;
      end
`endif
      m_pend = e | (m_pend & ~ifc.i_ack);
      for (int i = HD - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = ifc.i_evt;
    end
    x.pend = m_pend;
    for (int c = 0; c < NUM_CH; c++) x.cnt[c*CNT_W +: CNT_W] = m_cnt[c];
    sb_q.push_back(x);
  endtask

  // One clock: predict, clock, then pop and compare away from the edge.
  task automatic tick(input string tag);
    exp_t x;
    model_step();
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s scoreboard empty got 1 expected 0", tag);
    end else begin
      x = sb_q.pop_front();
      chk({tag, "_pend"}, 32'(ifc.o_pending), 32'(x.pend));
      chk({tag, "_irq"},  32'(ifc.o_irq),     32'(|(x.pend & ifc.i_mask)));
      chk({tag, "_cnt"},  32'(ifc.o_miss_cnt), 32'(x.cnt));
    end
  endtask

  function automatic logic [CNT_W-1:0] cnt_of(input int c);
    logic [NUM_CH*CNT_W-1:0] v;
    v = ifc.o_miss_cnt;
    return v[c*CNT_W +: CNT_W];
  endfunction

`ifdef BOTUPDT_MISS_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  initial begin
    rst = 1'b1;
    ifc.i_evt = '0; ifc.i_mask = 4'hF; ifc.i_ack = '0; ifc.i_cnt_clr = 1'b0;

    // 1: reset then single rising edge on ch0, latency to pending
    repeat (3) tick("rst");
    chk("rst_pend", 32'(ifc.o_pending), 32'h0);
    chk("rst_irq",  32'(ifc.o_irq), 32'h0);
    rst = 1'b0;
    ifc.i_evt = 4'b0001;
    tick("lat_k");
    tick("lat_k1");
    tick("lat_k2");
    chk("lat_before", 32'(ifc.o_pending), 32'h0);
    tick("lat_k3");
    chk("lat_pend", 32'(ifc.o_pending), 32'h1);
    chk("lat_irq",  32'(ifc.o_irq), 32'h1);

    // 2: ack clears, second ack on idle channel is harmless
    ifc.i_ack = 4'b0001; tick("ack0"); ifc.i_ack = '0;
    chk("ack_pend", 32'(ifc.o_pending), 32'h0);
    chk("ack_irq",  32'(ifc.o_irq), 32'h0);
    ifc.i_ack = 4'b0001; tick("ack_idle"); ifc.i_ack = '0;
    tick("ack_idle2");
    chk("ack_idle_pend", 32'(ifc.o_pending), 32'h0);

    // 3: edge and ack in same cycle on pending ch1
    ifc.i_evt = 4'b0011;
    repeat (4) tick("ch1_set");
    ifc.i_evt = 4'b0001;
    repeat (2) tick("ch1_low");
    ifc.i_evt = 4'b0011;
    repeat (3) tick("ch1_rise");
    ifc.i_ack = 4'b0010; tick("ch1_coinc"); ifc.i_ack = '0;
    chk("coinc_pend", 32'(ifc.o_pending[1]), 32'h1);
    chk("coinc_cnt",  32'(cnt_of(1)), 32'h0);
    ifc.i_ack = 4'b0010; tick("ch1_clr"); ifc.i_ack = '0;

    // 4: missed-edge counter saturation and clear
    ifc.i_evt = 4'b0111;
    repeat (4) tick("ch2_set");
    for (int n = 0; n < 9; n++) begin
      ifc.i_evt = 4'b0011; tick("ch2_lo");
      ifc.i_evt = 4'b0111; tick("ch2_hi");
    end
    repeat (4) tick("ch2_flush");
    chk("sat_cnt", 32'(cnt_of(2)), CNT_ON ? 32'd7 : 32'd0);
    ifc.i_cnt_clr = 1'b1; tick("cnt_clr"); ifc.i_cnt_clr = 1'b0;
    chk("clr_cnt", 32'(cnt_of(2)), 32'h0);
    ifc.i_evt = 4'b0011; tick("ch2_lo2");
    ifc.i_evt = 4'b0111;
    repeat (3) tick("ch2_rise2");
    ifc.i_cnt_clr = 1'b1; tick("clr_coinc"); ifc.i_cnt_clr = 1'b0;
    chk("clr_coinc_cnt", 32'(cnt_of(2)), CNT_ON ? 32'd1 : 32'd0);

    // 5: masked channel latches without irq; unmask raises irq immediately
    ifc.i_ack = 4'hF; tick("ack_all"); ifc.i_ack = '0;
    ifc.i_mask = 4'b0111;
    ifc.i_evt = 4'hF;
    repeat (4) tick("ch3_set");
    chk("mask_pend", 32'(ifc.o_pending), 32'h8);
    chk("mask_irq",  32'(ifc.o_irq), 32'h0);
    ifc.i_mask = 4'hF;
    #1;
    chk("unmask_irq", 32'(ifc.o_irq), 32'h1);

    // 6: level high through reset, then mid-stream reset
    rst = 1'b1;
    repeat (2) tick("rst2");
    rst = 1'b0;
    repeat (3) tick("hold_pre");
    chk("hold_pre_pend", 32'(ifc.o_pending), 32'h0);
    tick("hold_k3");
    chk("hold_pend", 32'(ifc.o_pending), 32'hF);
    ifc.i_evt = 4'h5; tick("mid_lo");
    ifc.i_evt = 4'hF; repeat (2) tick("mid_hi");
    rst = 1'b1; tick("mid_rst");
    chk("mid_rst_pend", 32'(ifc.o_pending), 32'h0);
    chk("mid_rst_irq",  32'(ifc.o_irq), 32'h0);
    chk("mid_rst_cnt",  32'(ifc.o_miss_cnt), 32'h0);
    rst = 1'b0;
    repeat (4) tick("resample");
    chk("resample_pend", 32'(ifc.o_pending), 32'hF);

    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
